uba_page_xlate: RTL
===================

// Module: uba_page_xlate
// PURPOSE
//  Parametrised, pipelined IO-bridge page translator with a self-clearing page table.
//  - Maps a device virtual page number (VPN) to a KS10 physical page number (PPN) plus per-page flags.
//  - Clears every entry by itself after reset.
//  - Registers translations with a req/ack handshake.
//  - Captures the first page failure in a sticky fault register.
//  - Sits between UBA device DMA and the KS10 bus master. KS10 IO writes program the table.
// PARAMETERS
//  VPN_W   6   virtual page bits. Page table has 2**VPN_W entries. VPN_W+WORD_W must equal 15.
//  PPN_W   11  physical page bits. Range 1..14; PPN_W+WORD_W <= 20.
//  WORD_W  9   word-in-page bits.
// PORTS
//  clk        in   1   clock. Single clock domain.
//  rst        in   1   reset. Synchronous, active-high.
//  busADDRI   in   36  KS10 IO address. Table index = busADDRI[36-VPN_W:35].
//  busDATAI   in   36  KS10 write data. Flags RPW,E16,FTM,VLD = [18:21]; PPN = [36-PPN_W:35].
//  pageWRITE  in   1   table write strobe.
//  pageDATAO  out  36  table read data. Flags at [5:8]; PPN at [27-PPN_W:26]; all other bits 0.
//  devREQI    in   1   translation request.
//  devADDRI   in   36  device address. A17=[18]; VPN=[19:18+VPN_W]; word=[34-WORD_W:33].
//  devACKO    out  1   translation result valid.
//  busADDRO   out  36  {devADDRI[0:35-PPN_W-WORD_W], PPN, word}.
//  flagsO     out  3   {RPW,E16,FTM} of the translated page.
//  pageNXM    out  1   translation failed.
//  faultVLD   out  1   sticky: a page failure has been captured.
//  faultADDR  out  36  devADDRI of the first captured failure.
//  faultCLR   in   1   clears faultVLD and faultADDR.
//  initBUSY   out  1   table clear sweep in progress.
// BEHAVIOUR
//  Reset values
//  - Clocked outputs are 0 during and after rst.
//  - initBUSY is 1 from the first clock after rst asserts until the sweep ends.
//  Init state machine: states INIT and RUN.
//  - rst forces INIT with cnt=0. This applies at any time, including mid-sweep or mid-request.
//  - In INIT, each cycle writes entry[cnt] <= 0 and then increments cnt.
//  - When cnt==2**VPN_W-1, that entry is cleared and the next state is RUN. The sweep lasts exactly 2**VPN_W cycles.
//  - In INIT: pageWRITE and devREQI are ignored, devACKO=0, and pageDATAO=0.
//  Table write
//  - In RUN, pageWRITE at edge N stores {flags,PPN} into entry[busADDRI VPN].
//  - Busbits [22:35-PPN_W] are discarded.
//  Table read
//  - pageDATAO is combinational from the entry at busADDRI VPN, formatted as described under PORTS.
//  Translation pipeline
//  - Latency is 1 cycle. A request in RUN sampled at edge N produces devACKO=1 with busADDRO, flagsO and pageNXM valid after edge N.
//  - One request is accepted per cycle. devACKO=0 in every cycle without a request.
//  - A request sampled on the last INIT cycle is dropped.
//  NXM rule
//  - pageNXM = devADDRI[18] | ~VLD.
//  - When pageNXM=1: busADDRO=0 and flagsO=0.
//  Write/lookup collision
//  - pageWRITE and devREQI in the same cycle on the same VPN: the lookup uses the NEW entry (write forwarding).
//  - Different VPNs do not interact.
//  Fault register
//  - On an acked NXM with faultVLD=0: faultVLD<=1 and faultADDR<=devADDRI.
//  - While faultVLD=1, later NXMs do not overwrite faultADDR.
//  - faultCLR together with a new NXM in the same cycle: the new fault is captured (set wins).
//  Width rules
//  - Parameter violations stop elaboration with $error.
//  - All fields are MSB-first, matching the big-endian KS10 numbering.
// TESTING
//  T1 Reset and sweep
//   - Stimulus: pulse rst.
//   - Required: initBUSY=1 for exactly 64 cycles; devREQI during the sweep gives no devACKO.
//   - Then every VPN reads pageDATAO=0 and every request gives pageNXM=1.
//  T2 Basic translation
//   - Stimulus: write VPN 5, RH=040443 octal (VLD=1, PPN=0443 octal). Then request with VPN 5, word 0253 octal, A17=0.
//   - Required: next cycle devACKO=1, busADDRO[16:35]=0x246AB, pageNXM=0.
//   - Required: pageDATAO LH bit 8 = 1 and the PPN field = 0443 octal.
//  T3 Faults
//   - Stimulus: request with A17=1, then a request to an invalid VPN 7.
//   - Required: both ack with pageNXM=1 and busADDRO=0; faultADDR holds the first address.
//   - Stimulus: faultCLR together with a third NXM.
//   - Required: faultVLD stays 1 and faultADDR holds the third address.
//  T4 Collision
//   - Stimulus: pageWRITE on VPN 9 (VLD=1, PPN=1) in the same cycle as a request to VPN 9.
//   - Required: ack with pageNXM=0 and PPN=1.
//  T5 Throughput
//   - Stimulus: 8 back-to-back requests to VPN 0..7.
//   - Required: 8 consecutive acks, in order, each translated correctly.
//  T6 Mid-sweep reset
//   - Stimulus: assert rst at sweep cycle 30, with a request in flight in RUN.
//   - Required: devACKO=0, the sweep restarts at 0, and initBUSY lasts a full 64 cycles.

Source files
------------

// File: rtl/uba_page_xlate.sv
// UBA IO-bridge page translator: self-clearing page table,
// one-cycle VPN->PPN lookup with NXM detection and a sticky fault capture.
module uba_page_xlate #(
  parameter int VPN_W  = 6,
  parameter int PPN_W  = 11,
  parameter int WORD_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] busADDRI,
  input  logic [35:0] busDATAI,
  input  logic        pageWRITE,
  output logic [35:0] pageDATAO,
  input  logic        devREQI,
  input  logic [35:0] devADDRI,
  output logic        devACKO,
  output logic [35:0] busADDRO,
  output logic [2:0]  flagsO,
  output logic        pageNXM,
  output logic        faultVLD,
  output logic [35:0] faultADDR,
  input  logic        faultCLR,
  output logic        initBUSY
);

  localparam int DEPTH = 1 << VPN_W;
  localparam int EW    = PPN_W + 4;
  localparam int HI_W  = 36 - PPN_W - WORD_W;

  if (VPN_W + WORD_W != 15) begin : g_bad_vpn
    $error("uba_page_xlate: VPN_W + WORD_W must equal 15");
  end
  if (PPN_W < 1 || PPN_W > 14) begin : g_bad_ppn
    $error("uba_page_xlate: PPN_W must be in 1..14");
  end
  if (PPN_W + WORD_W > 20) begin : g_bad_sum
    $error("uba_page_xlate: PPN_W + WORD_W must be <= 20");
  end

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [VPN_W-1:0]   cnt_q;
  logic [VPN_W-1:0]   cnt_d;
  logic               clr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    unique case (state_q)
      INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == VPN_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  logic               run;
  logic               wr_en;
  logic               req_en;
  logic [VPN_W-1:0]   wr_idx;
  logic [EW-1:0]      wr_ent;
  logic [VPN_W-1:0]   req_vpn;
  logic [EW-1:0]      tbl [DEPTH];

  assign run     = (state_q == RUN);
  assign initBUSY = (state_q == INIT);
  assign wr_en   = run & pageWRITE;
  assign req_en  = run & devREQI;
  assign wr_idx  = busADDRI[VPN_W-1:0];
  assign wr_ent  = {busDATAI[17:14], busDATAI[PPN_W-1:0]};
  assign req_vpn = devADDRI[16 -: VPN_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        tbl[cnt_q] <= '0;
      end else if (wr_en) begin
        tbl[wr_idx] <= wr_ent;
      end
    end
  end

  // same-cycle write to the requested page is forwarded to the lookup
  logic               hit;
  logic [EW-1:0]      ent;
  logic               nxm;
  logic [35:0]        xl_addr;

  assign hit     = wr_en && (wr_idx == req_vpn);
  assign ent     = hit ? wr_ent : tbl[req_vpn];
  assign nxm     = devADDRI[17] | ~ent[PPN_W];
  assign xl_addr = {devADDRI[35 -: HI_W], ent[PPN_W-1:0],
                    devADDRI[WORD_W+1:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      devACKO  <= 1'b0;
      busADDRO <= '0;
      flagsO   <= '0;
      pageNXM  <= 1'b0;
    end else begin
      devACKO  <= req_en;
      busADDRO <= (req_en && !nxm) ? xl_addr : '0;
      flagsO   <= (req_en && !nxm) ? ent[EW-1:PPN_W+1] : '0;
      pageNXM  <= req_en & nxm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      faultVLD  <= 1'b0;
      faultADDR <= '0;
    end else if (req_en && nxm && (!faultVLD || faultCLR)) begin
      faultVLD  <= 1'b1;
      faultADDR <= devADDRI;
    end else if (faultCLR) begin
      faultVLD  <= 1'b0;
      faultADDR <= '0;
    end
  end

  logic [EW-1:0] rd_ent;

  assign rd_ent = tbl[busADDRI[VPN_W-1:0]];

  always_comb begin
    pageDATAO = '0;
    if (run) begin
      pageDATAO[30:27]      = rd_ent[EW-1:PPN_W];
      pageDATAO[PPN_W+8:9]  = rd_ent[PPN_W-1:0];
    end
  end

  logic unused_bits;

  assign unused_bits = ^{busADDRI, busDATAI, devADDRI};

endmodule
